// File: rtl/node_pkg.sv
// Shared types for the streaming node blocks: skid buffer state and occupancy decode.
package node_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  function automatic logic [1:0] occ_of(input skid_state_t s);
    case (s)
      BUSY:    occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: every output is a flop, so upstream and downstream
// timing paths are fully decoupled while still sustaining one word per cycle.
module skid_buffer
  import node_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_up_in,
  output logic             ready_up_out,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_down_out,
  input  logic             ready_down_in,
  output logic [1:0]       occupancy
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q, valid_q;
  logic [1:0]       occ_q;
  logic             up_fire, down_fire;

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    up_fire   = valid_up_in & ready_q;
    down_fire = valid_q & ready_down_in;
    case (state_q)
      EMPTY: begin
        if (up_fire) begin
          main_d  = data_in;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (up_fire && down_fire) begin
          main_d = data_in;
        end else if (up_fire) begin
          skid_d  = data_in;
          state_d = FULL;
        end else if (down_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready is low here, so only the downstream side can move
        if (down_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != FULL);
      valid_q <= (state_d != EMPTY);
      occ_q   <= occ_of(state_d);
    end
  end

  assign ready_up_out   = ready_q;
  assign valid_down_out = valid_q;
  assign data_out       = main_q;
  assign occupancy      = occ_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Bench for skid_buffer: a FIFO-of-two queue model predicts every output each cycle.
module tb_skid_buffer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             valid_up_in;
  logic             ready_up_out;
  logic [WIDTH-1:0] data_out;
  logic             valid_down_out;
  logic             ready_down_in;
  logic [1:0]       occupancy;

  int checks = 0;
  int fails  = 0;

  logic [WIDTH-1:0] mq[$];
  bit               hold_ready_low = 1'b1;
  int               pops = 0;

  skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_up_in(valid_up_in),
    .ready_up_out(ready_up_out), .data_out(data_out), .valid_down_out(valid_down_out),
    .ready_down_in(ready_down_in), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic bit exp_ready();
    return !hold_ready_low && (mq.size() < 2);
  endfunction

  function automatic bit exp_valid();
    return mq.size() > 0;
  endfunction

  function automatic logic [WIDTH-1:0] exp_head();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  task automatic drive(input logic [WIDTH-1:0] d, input bit v, input bit r);
    data_in = d; valid_up_in = v; ready_down_in = r;
  endtask

  // Advance model across the coming edge, then wait for it; called at the negedge.
  task automatic tick();
    bit up, down;
    up   = valid_up_in && exp_ready();
    down = exp_valid() && ready_down_in;
    if (rst) begin
      mq.delete();
      hold_ready_low = 1'b1;
    end else begin
      if (down) begin void'(mq.pop_front()); pops++; end
      if (up) mq.push_back(data_in);
      hold_ready_low = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive('0, 1'b0, 1'b1);
    @(negedge clk); tick();
    @(negedge clk); tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ready_up_out !== 1'b0) begin fails++; $display("FAIL reset_ready0 got=%b exp=0", ready_up_out); end
    checks++; if (valid_down_out !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid_down_out); end
    checks++; if (data_out !== '0) begin fails++; $display("FAIL reset_data got=%h exp=0", data_out); end
    checks++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    tick();
    @(negedge clk);
    checks++; if (ready_up_out !== 1'b1) begin fails++; $display("FAIL reset_ready1 got=%b exp=1", ready_up_out); end
    tick();
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 11; i++) begin
      if (i <= 8) drive(WIDTH'(i), 1'b1, 1'b1); else drive('0, 1'b0, 1'b1);
      @(negedge clk);
      checks++; if (valid_down_out !== exp_valid()) begin fails++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, valid_down_out, exp_valid()); end
      if (exp_valid()) begin
        checks++; if (data_out !== exp_head()) begin fails++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", i, data_out, exp_head()); end
      end
      if (i >= 2 && i <= 9) begin
        checks++; if (data_out !== WIDTH'(i - 1) || occupancy !== 2'd1) begin
          fails++; $display("FAIL stream_latency cyc=%0d got=%h/%0d exp=%h/1", i, data_out, occupancy, i - 1);
        end
      end
      checks++; if (ready_up_out !== exp_ready()) begin fails++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", i, ready_up_out, exp_ready()); end
      tick();
    end
  endtask

  task automatic test_full();
    drive(32'hA, 1'b1, 1'b0); @(negedge clk); tick();
    drive(32'hB, 1'b1, 1'b0); @(negedge clk); tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'hF, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (occupancy !== 2'd2) begin fails++; $display("FAIL full_occ got=%0d exp=2", occupancy); end
      checks++; if (ready_up_out !== 1'b0) begin fails++; $display("FAIL full_ready got=%b exp=0", ready_up_out); end
      checks++; if (data_out !== 32'hA || valid_down_out !== 1'b1) begin fails++; $display("FAIL full_hold got=%h/%b exp=a/1", data_out, valid_down_out); end
      tick();
    end
    drive('0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (data_out !== 32'hA) begin fails++; $display("FAIL drain_first got=%h exp=a", data_out); end
    tick();
    @(negedge clk);
    checks++; if (data_out !== 32'hB || valid_down_out !== 1'b1 || occupancy !== 2'd1) begin
      fails++; $display("FAIL drain_second got=%h/%b/%0d exp=b/1/1", data_out, valid_down_out, occupancy);
    end
    tick();
    @(negedge clk);
    checks++; if (valid_down_out !== 1'b0 || occupancy !== 2'd0) begin fails++; $display("FAIL drain_empty got=%b/%0d exp=0/0", valid_down_out, occupancy); end
    tick();
  endtask

  task automatic test_random();
    int sent = 0;
    int start_pops = pops;
    int cyc = 0;
    logic [WIDTH-1:0] word = $urandom;
    while ((sent < 1000 || mq.size() > 0) && cyc < 20000) begin
      bit v, r;
      v = (sent < 1000) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      drive(word, v, r);
      @(negedge clk);
      checks++; if (valid_down_out !== exp_valid()) begin fails++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, valid_down_out, exp_valid()); end
      if (exp_valid()) begin
        checks++; if (data_out !== exp_head()) begin fails++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, data_out, exp_head()); end
      end
      checks++; if (ready_up_out !== exp_ready()) begin fails++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, ready_up_out, exp_ready()); end
      checks++; if (occupancy !== 2'(mq.size())) begin fails++; $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", cyc, occupancy, mq.size()); end
      if (v && exp_ready()) begin sent++; word = $urandom; end
      tick();
      cyc++;
    end
    checks++; if (pops - start_pops != 1000) begin fails++; $display("FAIL rand_count got=%0d exp=1000 cycles=%0d", pops - start_pops, cyc); end
  endtask

  task automatic test_reset_full();
    drive(32'h11, 1'b1, 1'b0); @(negedge clk); tick();
    drive(32'h22, 1'b1, 1'b0); @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (occupancy !== 2'd2) begin fails++; $display("FAIL rfull_pre got=%0d exp=2", occupancy); end
    rst = 1'b1; drive(32'h33, 1'b1, 1'b0);
    tick();
    rst = 1'b0; drive('0, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (occupancy !== 2'd0 || valid_down_out !== 1'b0 || ready_up_out !== 1'b0 || data_out !== '0) begin
      fails++; $display("FAIL rfull_post got=occ%0d v%b r%b d%h exp=occ0 v0 r0 d0", occupancy, valid_down_out, ready_up_out, data_out);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (valid_down_out !== 1'b0) begin fails++; $display("FAIL rfull_stale cyc=%0d got=%b exp=0", i, valid_down_out); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h5, 1'b1, 1'b0); @(negedge clk); tick();
    drive(32'hC, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (occupancy !== 2'd1 || data_out !== 32'h5) begin fails++; $display("FAIL b2b_pre got=%h/%0d exp=5/1", data_out, occupancy); end
    tick();
    drive('0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (data_out !== 32'hC || occupancy !== 2'd1 || valid_down_out !== 1'b1) begin
      fails++; $display("FAIL b2b_post got=%h/%0d/%b exp=c/1/1", data_out, occupancy, valid_down_out);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive('0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_stream();
    test_full();
    test_random();
    test_reset_full();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
